bcd_counter_ndigit: RTL and testbench

//   Parametrised multi-digit synchronous BCD counter: DIGITS cascaded decades,
//   up/down, enable, synchronous clear and parallel load, optional clock-enable

---
 rtl/bcd_counter_ndigit.sv | 115 +++++++++++
 tb/tb_bcd_counter_ndigit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit synchronous BCD up/down counter with parallel load, clear,
// clock-enable prescaler, terminal-count and wrap flags.
module bcd_counter_ndigit #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);
    localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    // Illegal digits (>9) are replaced by 0 so the count never leaves BCD space.
    function automatic logic [4*DIGITS-1:0] bcd_sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic bcd_invalid(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    logic [4*DIGITS-1:0] bcd_r;
    logic [PW-1:0]       pcnt_r;
    logic                wrap_r;
    logic                load_err_r;
    logic [4*DIGITS-1:0] nxt_s;
    logic                step_s;
    logic                lo9_s;
    logic                lo0_s;
    logic                tc_s;

    // Next count value: carry/borrow ripples through all lower digits in one cycle.
    always_comb begin
        step_s = en & (pcnt_r == PLAST);
        nxt_s  = bcd_r;
        lo9_s  = 1'b1;
        lo0_s  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (up) begin
                if (lo9_s) begin
                    nxt_s[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd9) ? 4'd0 : bcd_r[4*i +: 4] + 4'd1;
                end else begin
                    nxt_s[4*i +: 4] = bcd_r[4*i +: 4];
                end
            end else begin
                if (lo0_s) begin
                    nxt_s[4*i +: 4] = (bcd_r[4*i +: 4] == 4'd0) ? 4'd9 : bcd_r[4*i +: 4] - 4'd1;
                end else begin
                    nxt_s[4*i +: 4] = bcd_r[4*i +: 4];
                end
            end
            lo9_s = lo9_s & (bcd_r[4*i +: 4] == 4'd9);
            lo0_s = lo0_s & (bcd_r[4*i +: 4] == 4'd0);
        end
        // After the loop lo9_s/lo0_s describe the whole counter.
        tc_s = step_s & (up ? lo9_s : lo0_s);
    end

    // Count, prescaler and flag registers; priority rst > clr > load > step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bcd_r      <= '0;
            pcnt_r     <= '0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else if (clr) begin
            bcd_r      <= '0;
            pcnt_r     <= '0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else if (load) begin
            bcd_r      <= bcd_sanitize(load_val);
            pcnt_r     <= '0;
            wrap_r     <= 1'b0;
            load_err_r <= bcd_invalid(load_val);
        end else begin
            load_err_r <= 1'b0;
            wrap_r     <= tc_s;
            if (en) begin
                pcnt_r <= step_s ? '0 : pcnt_r + PW'(1);
                if (step_s) begin
                    bcd_r <= nxt_s;
                end
            end
        end
    end

    assign bcd      = bcd_r;
    assign tc       = tc_s;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Randomised self-checking bench: a 4-digit undivided counter and a 2-digit
// prescale-by-5 counter share controls and are compared to an integer model.
module tb_bcd_counter_ndigit;
    logic        clk = 1'b0;
    logic        rst, en, up, clr, load;
    logic [15:0] lv;
    logic [15:0] bcd0;
    logic [7:0]  bcd1;
    logic        tc0, wrap0, err0, tc1, wrap1, err1;

    int checks   = 0;
    int failures = 0;
    int wraps1   = 0;

    int ndig[2] = '{4, 2};
    int npre[2] = '{1, 5};
    int m_val[2];
    int m_pc[2];
    bit m_wrap[2];
    bit m_err[2];

    always #5 clk = ~clk;

    bcd_counter_ndigit #(.DIGITS(4), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .bcd(bcd0), .tc(tc0), .wrap(wrap0), .load_err(err0)
    );

    bcd_counter_ndigit #(.DIGITS(2), .PRESCALE(5)) u_pre (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .bcd(bcd1), .tc(tc1), .wrap(wrap1), .load_err(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int modulus(input int k);
        int m = 1;
        for (int i = 0; i < ndig[k]; i++) m = m * 10;
        return m;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit exp_tc(input int k);
        bit at_end;
        at_end = up ? (m_val[k] == modulus(k) - 1) : (m_val[k] == 0);
        return en && (m_pc[k] == npre[k] - 1) && at_end;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst || clr) begin
                m_val[k] = 0; m_pc[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
            end else if (load) begin
                int v = 0;
                bit bad = 0;
                for (int i = ndig[k] - 1; i >= 0; i--) begin
                    int d = (int'(lv) >> (4 * i)) & 15;
                    if (d > 9) begin bad = 1; d = 0; end
                    v = v * 10 + d;
                end
                m_val[k] = v; m_err[k] = bad; m_pc[k] = 0; m_wrap[k] = 0;
            end else begin
                bit step = en && (m_pc[k] == npre[k] - 1);
                m_wrap[k] = exp_tc(k);
                m_err[k]  = 0;
                if (en) m_pc[k] = step ? 0 : m_pc[k] + 1;
                if (step) m_val[k] = up ? (m_val[k] + 1) % modulus(k)
                                        : (m_val[k] + modulus(k) - 1) % modulus(k);
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_eq("tc0", tc0, exp_tc(0));
        check_eq("tc1", tc1, exp_tc(1));
        @(posedge clk);
        model_edge();
        #1;
        if (wrap1) wraps1++;
        check_eq("bcd0", bcd0, to_bcd(m_val[0], 4));
        check_eq("bcd1", bcd1, to_bcd(m_val[1], 2));
        check_eq("wrap0", wrap0, m_wrap[0]);
        check_eq("wrap1", wrap1, m_wrap[1]);
        check_eq("err0", err0, m_err[0]);
        check_eq("err1", err1, m_err[1]);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv = 16'h0000;
        repeat (3) cycle();
        check_eq("reset_bcd", bcd0, 32'h0);
        check_eq("reset_flags", {wrap0, err0, wrap1, err1}, 32'h0);

        // Free run: 500 cycles = 100 prescaled steps, one wrap on the 2-digit counter.
        rst = 1'b1; en = 1'b1; up = 1'b1;
        repeat (500) cycle();
        check_eq("run_wraps", wraps1, 32'd1);
        check_eq("run_bcd1", bcd1, 32'h00);
        check_eq("run_bcd0", bcd0, 32'h0500);

        // Carry across digits, then borrow back.
        en = 1'b0; load = 1'b1; lv = 16'h0999; cycle();
        load = 1'b0; en = 1'b1; up = 1'b1; cycle();
        check_eq("inc_carry", bcd0, 32'h1000);
        en = 1'b0; load = 1'b1; lv = 16'h1000; cycle();
        load = 1'b0; en = 1'b1; up = 1'b0; cycle();
        check_eq("dec_borrow", bcd0, 32'h0999);

        // Down wrap from all-zero.
        en = 1'b0; load = 1'b1; lv = 16'h0000; cycle();
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1 check_eq("tc_down", tc0, 32'h1);
        cycle();
        check_eq("down_wrap_bcd", bcd0, 32'h9999);
        check_eq("down_wrap_pulse", wrap0, 32'h1);
        en = 1'b0; cycle();
        check_eq("wrap_one_cycle", wrap0, 32'h0);

        // Prescaler: 25 enabled cycles with a 3-cycle pause give 5 steps.
        clr = 1'b1; up = 1'b1; cycle();
        clr = 1'b0; en = 1'b1;
        repeat (10) cycle();
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        repeat (15) cycle();
        check_eq("prescale_count", bcd1, 32'h05);

        // Illegal digits on load, then clr overriding load.
        en = 1'b0; load = 1'b1; lv = 16'h3A7F; cycle();
        check_eq("load_sanitize", bcd0, 32'h3070);
        check_eq("load_err_pulse", err0, 32'h1);
        load = 1'b0; cycle();
        check_eq("load_err_clear", err0, 32'h0);
        clr = 1'b1; load = 1'b1; lv = 16'hA123; cycle();
        check_eq("clr_over_load", bcd0, 32'h0);
        check_eq("clr_no_err", err0, 32'h0);
        clr = 1'b0; load = 1'b0;

        // Reset mid-count wins over load and enable.
        en = 1'b1; up = 1'b1; repeat (7) cycle();
        rst = 1'b0; load = 1'b1; lv = 16'h1234; cycle();
        check_eq("rst_mid_bcd", bcd0, 32'h0);
        check_eq("rst_mid_flags", {wrap0, err0}, 32'h0);
        rst = 1'b1; load = 1'b0;

        // Random traffic with boundary-biased loads.
        for (int n = 0; n < 2000; n++) begin
            rst  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            clr  = ($urandom_range(0, 99) < 3);
            load = ($urandom_range(0, 99) < 6);
            en   = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 5) up = ~up;
            case ($urandom_range(0, 3))
                0:       lv = 16'h9999;
                1:       lv = 16'h0000;
                2:       lv = 16'h9998;
                default: lv = 16'($urandom);
            endcase
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
